// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler: op encoding and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative LSB-first shift-add multiplier: W iterations after a start cycle.
// done/product are combinational during the final iteration so the caller can commit on that edge.
module alu_seq_mul #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned    CntW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  logic            run_q, run_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_sum;
  logic            last;

  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last     = run_q && (cnt_q == CntLast);
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
    end else if (run_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign done    = last;
  assign product = acc_sum;

endmodule

// File: rtl/alu_share_sched.sv
// Two-requester round-robin scheduler in front of one add/sub/clear/multiply datapath.
// EXEC opens with an issue cycle (operand stage / multiplier start) before the op completes.
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [1:0]     req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [1:0]     req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           busy,
  output logic           done,
  output logic           done_id,
  output logic [1:0]     done_op,
  output logic [2*W-1:0] result
);

  state_e         state_q, state_d;
  logic           issue_q, issue_d;
  logic           id_q, id_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] arith_q, arith_d;
  logic           last_id_q, last_id_d;
  logic [2*W-1:0] result_q, result_d;
  logic           done_id_q, done_id_d;
  logic [1:0]     done_op_q, done_op_d;

  logic           gnt0, gnt1, in_idle, accept, acc_id;
  logic           enter_done, mul_start, mul_done;
  logic [2*W-1:0] mul_product, a_ext, b_ext, arith_calc;

  // Contention goes to whoever was not served last; last_id resets to 1 so req0 wins first.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last_id_q);
    gnt1       = req1_valid && (!req0_valid || !last_id_q);
    in_idle    = (state_q == ST_IDLE) && !rst;
    req0_ready = in_idle && gnt0;
    req1_ready = in_idle && gnt1;
    accept     = req0_ready || req1_ready;
    acc_id     = req1_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: if (!issue_q && ((op_q != OP_MUL) || mul_done)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ext = {{W{1'b0}}, a_q};
    b_ext = {{W{1'b0}}, b_q};
    case (op_q)
      OP_ADD:  arith_calc = a_ext + b_ext;
      OP_SUB:  arith_calc = a_ext - b_ext;
      default: arith_calc = '0;
    endcase
  end

  assign mul_start  = (state_q == ST_EXEC) && issue_q && (op_q == OP_MUL);
  assign enter_done = (state_q == ST_EXEC) && (state_d == ST_DONE);

  always_comb begin
    issue_d   = 1'b0;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    arith_d   = arith_q;
    last_id_d = last_id_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    done_op_d = done_op_q;
    if (accept) begin
      issue_d   = 1'b1;
      id_d      = acc_id;
      op_d      = acc_id ? req1_op : req0_op;
      a_d       = acc_id ? req1_a : req0_a;
      b_d       = acc_id ? req1_b : req0_b;
      last_id_d = acc_id;
    end
    if ((state_q == ST_EXEC) && issue_q) arith_d = arith_calc;
    if (enter_done) begin
      result_d  = (op_q == OP_MUL) ? mul_product : arith_q;
      done_id_d = id_q;
      done_op_d = op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      issue_q   <= 1'b0;
      id_q      <= 1'b0;
      op_q      <= OP_CLR;
      a_q       <= '0;
      b_q       <= '0;
      arith_q   <= '0;
      last_id_q <= 1'b1;
      result_q  <= '0;
      done_id_q <= 1'b0;
      done_op_q <= OP_CLR;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      id_q      <= id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      arith_q   <= arith_d;
      last_id_q <= last_id_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      done_op_q <= done_op_d;
    end
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    done_id = done_id_q;
    done_op = done_op_q;
    result  = result_q;
  end

  alu_seq_mul #(
    .W(W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_alu_share_sched.sv
// Randomized self-checking bench for alu_share_sched against a plain-arithmetic reference.
module tb_alu_share_sched;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          busy, done, done_id;
  logic [1:0]    done_op;
  logic [RW-1:0] result;

  int checks   = 0;
  int failures = 0;
  bit ref_last;  // requester served most recently, per the round-robin rule

  always #5 clk = ~clk;

  alu_share_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .busy(busy), .done(done), .done_id(done_id), .done_op(done_op), .result(result)
  );

  function automatic logic [RW-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (op)
      2'd0:    return '0;
      2'd1:    return RW'(ia + ib);
      2'd2:    return RW'(ia - ib);
      default: return RW'(ia * ib);
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    return (op == 2'd3) ? W + 2 : 3;
  endfunction

  task automatic run_cmd(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat, output logic [RW-1:0] res,
                         output logic rid, output logic [1:0] rop, output bit got_rdy,
                         output bit one_pulse);
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    got_rdy = 1'b0; lat = -1; res = 'x; rid = 'x; rop = 'x; one_pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin got_rdy = 1'b1; break; end
      @(negedge clk);
    end
    if (!got_rdy) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; res = result; rid = done_id; rop = done_op; break; end
    end
    if (lat > 0) begin @(negedge clk); one_pulse = (done === 1'b0); end
  endtask

  task automatic check_cmd(input string name, input bit id, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    int lat; logic [RW-1:0] res; logic rid; logic [1:0] rop; bit rdy, one;
    run_cmd(id, op, a, b, lat, res, rid, rop, rdy, one);
    ref_last = id;
    checks++;
    if (!rdy || lat != ref_lat(op) || !one) begin
      failures++;
      $display("FAIL %s_timing ready=%0b lat=%0d one_pulse=%0b exp_lat=%0d", name, rdy, lat, one,
               ref_lat(op));
    end
    checks++;
    if (res !== ref_alu(op, a, b)) begin
      failures++;
      $display("FAIL %s_result got=%h exp=%h", name, res, ref_alu(op, a, b));
    end
    checks++;
    if (rid !== id || rop !== op) begin
      failures++;
      $display("FAIL %s_tag got id=%b op=%b exp id=%b op=%b", name, rid, rop, id, op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 2'd1; req0_a = 8'd1; req0_b = 8'd2;
    req1_valid = 1'b1; req1_op = 2'd1; req1_a = 8'd3; req1_b = 8'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_id !== 1'b0 || done_op !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b id=%b op=%b exp 0/0/0/00", busy, done,
               done_id, done_op);
    end
    checks++;
    if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy=%b exp=0", busy); end
    ref_last = 1'b1;
  endtask

  task automatic test_add_basic();
    check_cmd("add_200_100", 1'b0, 2'd1, 8'd200, 8'd100);
  endtask

  task automatic test_sub_mul();
    check_cmd("sub_3_5", 1'b1, 2'd2, 8'd3, 8'd5);
    check_cmd("mul_255_255", 1'b1, 2'd3, 8'd255, 8'd255);
    check_cmd("add_max", 1'b0, 2'd1, 8'd255, 8'd255);
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ra[2], rb[2];
    logic [RW-1:0] exp_res;
    bit seen, exp_gid;
    int gid, lat;
    for (int r = 0; r < 2; r++) begin ra[r] = W'($urandom); rb[r] = W'($urandom); end
    req0_op = 2'd1; req0_a = ra[0]; req0_b = rb[0];
    req1_op = 2'd1; req1_a = ra[1]; req1_b = rb[1];
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      exp_gid = !ref_last;
      checks++;
      if (!seen || (req0_ready === 1'b1 && req1_ready === 1'b1) || req1_ready !== exp_gid) begin
        failures++;
        $display("FAIL rr_grant%0d got ready=%b%b exp_id=%0d", g, req1_ready, req0_ready, exp_gid);
        req0_valid = 1'b0; req1_valid = 1'b0;
        return;
      end
      gid = int'(exp_gid);
      ref_last = exp_gid;
      exp_res = ref_alu(2'd1, ra[gid], rb[gid]);
      @(posedge clk); #1;
      ra[gid] = W'($urandom); rb[gid] = W'($urandom);
      if (g == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      else if (gid == 1) begin req1_a = ra[1]; req1_b = rb[1]; end
      else begin req0_a = ra[0]; req0_b = rb[0]; end
      lat = -1;
      for (int k = 1; k <= W + 8; k++) begin
        @(negedge clk);
        if (done === 1'b1) begin lat = k; break; end
      end
      checks++;
      if (lat != 3 || done_id !== exp_gid || result !== exp_res) begin
        failures++;
        $display("FAIL rr_done%0d got lat=%0d id=%b res=%h exp lat=3 id=%b res=%h", g, lat,
                 done_id, result, exp_gid, exp_res);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] a0, b0;
    bit seen_done;
    req0_op = 2'd3; req0_a = W'($urandom_range(1, 255)); req0_b = W'($urandom_range(1, 255));
    req0_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && req0_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || result !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_mul got done_seen=%b res=%h busy=%b exp 0/0/0", seen_done, result,
               busy);
    end
    ref_last = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom);
    req0_op = 2'd1; req0_a = a0; req0_b = b0;
    req1_op = 2'd1; req1_a = W'($urandom); req1_b = W'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL post_reset_grant got=%b%b exp=01", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < W + 8 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || result !== ref_alu(2'd1, a0, b0)) begin
      failures++;
      $display("FAIL post_reset_add got done=%b id=%b res=%h exp 1/0/%h", done, done_id, result,
               ref_alu(2'd1, a0, b0));
    end
    ref_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_hold();
    logic [W-1:0] a1, b1, a0, b0;
    bit bad;
    int dk, rk;
    logic [RW-1:0] dres;
    logic did;
    a1 = W'($urandom); b1 = W'($urandom); a0 = W'($urandom); b0 = W'($urandom);
    req1_op = 2'd3; req1_a = a1; req1_b = b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && req1_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_op = 2'd1; req0_a = a0; req0_b = b0; req0_valid = 1'b1;
    bad = 1'b0; dk = 0; rk = 0; dres = 'x; did = 'x;
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && req0_ready === 1'b1) bad = 1'b1;
      if (done === 1'b1 && dk == 0) begin dk = k; dres = result; did = done_id; end
      if (busy === 1'b0 && req0_ready === 1'b1) begin rk = k; break; end
      req1_a = W'($urandom); req1_b = W'($urandom);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL busy_ready got=1 exp=0 while busy"); end
    checks++;
    if (dk != W + 2 || did !== 1'b1 || dres !== ref_alu(2'd3, a1, b1)) begin
      failures++;
      $display("FAIL busy_mul got lat=%0d id=%b res=%h exp lat=%0d id=1 res=%h", dk, did, dres,
               W + 2, ref_alu(2'd3, a1, b1));
    end
    checks++;
    if (rk != W + 3) begin failures++; $display("FAIL busy_accept got=%0d exp=%0d", rk, W + 3); end
    ref_last = 1'b0;
    if (rk == 0) begin req0_valid = 1'b0; return; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < W + 8 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || result !== ref_alu(2'd1, a0, b0)) begin
      failures++;
      $display("FAIL busy_add got done=%b id=%b res=%h exp 1/0/%h", done, done_id, result,
               ref_alu(2'd1, a0, b0));
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    check_cmd("clr_pre_add", 1'b0, 2'd1, 8'd200, 8'd100);
    check_cmd("clear", 1'b0, 2'd0, W'($urandom), W'($urandom));
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      check_cmd("rand", 1'($urandom), 2'($urandom), W'($urandom), W'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_add_basic();
    test_sub_mul();
    test_round_robin();
    test_reset_mid_mul();
    test_busy_hold();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
